// File: rtl/dfc_pkg.sv
// Shared encodings, sizes and types for the DFC host sequencer.
package dfc_pkg;

    localparam int N_BYTES   = 8;
    localparam int N_RESULTS = 4;
    localparam int RES_W     = 9;

    localparam logic [1:0] CMD_LOAD = 2'b00;
    localparam logic [1:0] CMD_FIFO = 2'b01;
    localparam logic [1:0] CMD_LIFO = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_GUARD,
        S_WAIT,
        S_RDCMD,
        S_COLLECT,
        S_DONE
    } state_t;

    // Latched job: byte k of the request lives in bytes[k].
    typedef struct packed {
        logic                      lifo;
        logic [N_BYTES-1:0][7:0]   bytes;
    } job_t;

    // Result beats in arrival order, beat k in slot k.
    typedef logic [N_RESULTS-1:0][RES_W-1:0] res_t;

    // Read command for the requested order.
    function automatic logic [1:0] rd_cmd(input logic lifo);
        return lifo ? CMD_LIFO : CMD_FIFO;
    endfunction

endpackage

// File: rtl/dfc_host_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
module dfc_host_timer #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expired
);

    logic [W-1:0] cnt;

    // Load takes priority; otherwise count down and saturate at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/dfc_host.sv
// DFC engine initiator: LOAD, stream 8 bytes, wait for idle, read 4 results.
module dfc_host
    import dfc_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int GUARD   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 job_valid,
    output logic                 job_ready,
    input  logic [63:0]          job_data,
    input  logic                 job_lifo,
    output logic                 res_valid,
    output logic [35:0]          res_data,
    output logic                 err,
    output logic [1:0]           cmd,
    output logic                 cmd_valid,
    output logic [7:0]           datain,
    input  logic                 busy,
    input  logic [RES_W-1:0]     dataout,
    input  logic                 output_valid
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = (GUARD > 1) ? $clog2(GUARD) : 1;
    // Timer is loaded one below TIMEOUT so it expires on the TIMEOUT-th
    // counted cycle.
    localparam logic [TW-1:0] T_START = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0] G_LAST  = GW'(GUARD - 1);
    localparam logic [2:0]    B_LAST  = 3'(N_BYTES - 1);

    state_t        state, state_d;
    job_t          job_q;
    res_t          buf_q, buf_d;
    logic [2:0]    idx_q, idx_d;
    logic [GW-1:0] g_q, g_d;
    logic [1:0]    beat_q, beat_d;

    logic [1:0]    cmd_d;
    logic          cmd_valid_d;
    logic [7:0]    datain_d;
    logic          job_ready_d;
    logic          res_valid_d;
    logic [35:0]   res_data_d;
    logic          err_d;

    logic          t_load, t_en, t_exp;
    logic          accept;

    assign accept = job_valid && job_ready;

    dfc_host_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (t_load),
        .load_val (T_START),
        .en       (t_en),
        .expired  (t_exp)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_d;
    end

    // Next state plus next values of every registered output, so outputs
    // line up with the state they belong to.
    always_comb begin
        state_d     = state;
        idx_d       = idx_q;
        g_d         = g_q;
        beat_d      = beat_q;
        buf_d       = buf_q;
        cmd_d       = cmd;
        cmd_valid_d = 1'b0;
        datain_d    = datain;
        res_valid_d = 1'b0;
        res_data_d  = res_data;
        err_d       = 1'b0;
        t_load      = 1'b0;
        t_en        = 1'b0;

        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_d     = S_LOAD;
                    cmd_d       = CMD_LOAD;
                    cmd_valid_d = 1'b1;
                    // Job is latched on this same edge, so byte0 comes
                    // straight from the request.
                    datain_d    = job_data[7:0];
                    buf_d       = '0;
                    beat_d      = '0;
                    idx_d       = '0;
                end
            end
            S_LOAD: begin
                state_d  = S_SEND;
                idx_d    = '0;
                datain_d = job_q.bytes[0];
            end
            S_SEND: begin
                if (idx_q == B_LAST) begin
                    state_d  = S_GUARD;
                    g_d      = '0;
                    datain_d = '0;
                end else begin
                    idx_d    = idx_q + 3'd1;
                    datain_d = job_q.bytes[idx_q + 3'd1];
                end
            end
            S_GUARD: begin
                // busy may not yet reflect the last byte; ignore it here.
                if (g_q == G_LAST) begin
                    state_d = S_WAIT;
                    t_load  = 1'b1;
                end else begin
                    g_d = g_q + 1'b1;
                end
            end
            S_WAIT: begin
                t_en = 1'b1;
                if (!busy) begin
                    state_d     = S_RDCMD;
                    cmd_d       = rd_cmd(job_q.lifo);
                    cmd_valid_d = 1'b1;
                end else if (t_exp) begin
                    state_d     = S_DONE;
                    res_valid_d = 1'b1;
                    err_d       = 1'b1;
                    res_data_d  = '0;
                end
            end
            S_RDCMD: begin
                state_d = S_COLLECT;
                t_load  = 1'b1;
            end
            S_COLLECT: begin
                t_en = 1'b1;
                if (output_valid) begin
                    buf_d[beat_q] = dataout;
                    beat_d        = beat_q + 2'd1;
                end
                // A 4th beat landing on the expiry cycle still counts.
                if (output_valid && (beat_q == 2'd3)) begin
                    state_d     = S_DONE;
                    res_valid_d = 1'b1;
                    res_data_d  = buf_d;
                end else if (t_exp) begin
                    state_d     = S_DONE;
                    res_valid_d = 1'b1;
                    err_d       = 1'b1;
                    res_data_d  = buf_d;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        job_ready_d = (state_d == S_IDLE);
    end

    // Datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            job_q     <= '0;
            buf_q     <= '0;
            idx_q     <= '0;
            g_q       <= '0;
            beat_q    <= '0;
            cmd       <= CMD_LOAD;
            cmd_valid <= 1'b0;
            datain    <= '0;
            job_ready <= 1'b1;
            res_valid <= 1'b0;
            res_data  <= '0;
            err       <= 1'b0;
        end else begin
            if (accept) begin
                job_q.lifo  <= job_lifo;
                job_q.bytes <= job_data;
            end
            buf_q     <= buf_d;
            idx_q     <= idx_d;
            g_q       <= g_d;
            beat_q    <= beat_d;
            cmd       <= cmd_d;
            cmd_valid <= cmd_valid_d;
            datain    <= datain_d;
            job_ready <= job_ready_d;
            res_valid <= res_valid_d;
            res_data  <= res_data_d;
            err       <= err_d;
        end
    end

endmodule

// File: tb/tb_dfc_host.sv
// Bench for dfc_host: engine model, directed jobs, result scoreboard.
module tb_dfc_host;
    import dfc_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        job_valid = 1'b0;
    logic        job_ready;
    logic [63:0] job_data = '0;
    logic        job_lifo = 1'b0;
    logic        res_valid;
    logic [35:0] res_data;
    logic        err;
    logic [1:0]  cmd;
    logic        cmd_valid;
    logic [7:0]  datain;
    logic        busy;
    logic [8:0]  dataout;
    logic        output_valid;

    always #5 clk = ~clk;

    dfc_host #(.TIMEOUT(64), .GUARD(2)) dut (
        .clk(clk), .reset(reset),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_data(job_data), .job_lifo(job_lifo),
        .res_valid(res_valid), .res_data(res_data), .err(err),
        .cmd(cmd), .cmd_valid(cmd_valid), .datain(datain),
        .busy(busy), .dataout(dataout), .output_valid(output_valid)
    );

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [35:0] data;
        logic        err;
        int          n_rd;
        logic [1:0]  rcmd;
    } exp_t;
    exp_t q[$];

    function automatic void chk(string nm, logic [63:0] a, logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, a, e);
        end
    endfunction

    // ---------------- engine model ----------------
    logic       stuck = 1'b0;
    logic       noise = 1'b0;
    logic [7:0] mb [8];
    int         lcnt, ccnt, rdel, bidx;
    logic       gap, rd_act, m_lifo;

    function automatic logic [8:0] beat(int k);
        int j;
        j = m_lifo ? (3 - k) : k;
        return {1'b0, mb[j]} + {1'b0, mb[j+4]};
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            busy <= 1'b0; lcnt <= 0; ccnt <= 0; rdel <= 0; bidx <= 0;
            gap <= 1'b0; rd_act <= 1'b0; m_lifo <= 1'b0;
            output_valid <= 1'b0; dataout <= '0;
        end else begin
            output_valid <= 1'b0;
            dataout <= '0;
            if (cmd_valid && cmd == CMD_LOAD) begin
                busy <= 1'b1;
                lcnt <= 8;
            end else if (lcnt != 0) begin
                mb[8-lcnt] <= datain;
                lcnt <= lcnt - 1;
                if (lcnt == 1) ccnt <= 3;
                if (noise && lcnt == 4) begin
                    output_valid <= 1'b1;
                    dataout <= 9'h155;
                end
            end else if (ccnt != 0) begin
                ccnt <= ccnt - 1;
                if (ccnt == 1 && !stuck) busy <= 1'b0;
            end
            if (cmd_valid && cmd != CMD_LOAD) begin
                rd_act <= 1'b1; rdel <= 2; bidx <= 0; gap <= 1'b0;
                m_lifo <= (cmd == CMD_LIFO);
            end else if (rd_act) begin
                if (rdel != 0) rdel <= rdel - 1;
                else if (noise && !gap) gap <= 1'b1;
                else begin
                    gap <= 1'b0;
                    output_valid <= 1'b1;
                    dataout <= (bidx < 4) ? beat(bidx) : 9'h1AA;
                    if (bidx == (noise ? 4 : 3)) rd_act <= 1'b0;
                    bidx <= bidx + 1;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    int         cyc = 0, load_cyc = 0, n_load = 0, n_rd = 0, viol = 0, n_res = 0;
    logic       prev_cv = 1'b0;
    logic [1:0] rcmd = 2'b00;

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (reset) begin
            n_load = 0; n_rd = 0; prev_cv = 1'b0;
        end else begin
            if (cmd_valid && prev_cv) viol++;
            if (cmd_valid && busy && cmd != CMD_LOAD) viol++;
            if (cmd_valid && cmd == CMD_LOAD) begin n_load++; load_cyc = cyc; end
            if (cmd_valid && cmd != CMD_LOAD) begin n_rd++; rcmd = cmd; end
            prev_cv = cmd_valid;
            if (res_valid) begin
                n_res++;
                if (q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_result: got %h want none", res_data);
                end else begin
                    e = q.pop_front();
                    chk("res_data", 64'(res_data), 64'(e.data));
                    chk("err", 64'(err), 64'(e.err));
                    chk("load_pulses", 64'(n_load), 64'd1);
                    chk("read_pulses", 64'(n_rd), 64'(e.n_rd));
                    if (e.n_rd > 0) chk("read_cmd", 64'(rcmd), 64'(e.rcmd));
                    if (e.err) chk("timeout_latency_le_75", 64'(cyc - load_cyc <= 75), 64'd1);
                end
                n_load = 0; n_rd = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic push(input logic [35:0] d, input logic er, input int nr, input logic [1:0] rc);
        exp_t e;
        e.data = d; e.err = er; e.n_rd = nr; e.rcmd = rc;
        q.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [63:0] d, input logic l, input logic hold);
        int n;
        n = 0;
        job_valid = 1'b1; job_data = d; job_lifo = l;
        while (!job_ready && n < 300) begin @(negedge clk); n++; end
        if (!job_ready) begin
            total++; bad++;
            $display("FAIL accept_timeout: got job_ready=0 want 1");
        end
        @(posedge clk);
        #1;
        if (!hold) job_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 400) begin @(negedge clk); n++; end
        if (q.size() != 0) begin
            total++; bad++;
            $display("FAIL drain_timeout: got %0d pending want 0", q.size());
            q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    localparam logic [63:0] D1 = 64'h0807060504030201;
    localparam logic [63:0] D2 = 64'h50463C32281E140A;
    localparam logic [63:0] D3 = 64'hC0D0E0F044332211;

    initial begin
        int r0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_job_ready", 64'(job_ready), 64'd1);
        chk("rst_cmd_valid", 64'(cmd_valid), 64'd0);
        chk("rst_cmd", 64'(cmd), 64'd0);
        chk("rst_datain", 64'(datain), 64'd0);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_res_data", 64'(res_data), 64'd0);
        chk("rst_err", 64'(err), 64'd0);

        // FIFO 01..08
        push({9'd12, 9'd10, 9'd8, 9'd6}, 1'b0, 1, CMD_FIFO);
        issue(D1, 1'b0, 1'b0);
        drain();

        // LIFO 01..08
        push({9'd6, 9'd8, 9'd10, 9'd12}, 1'b0, 1, CMD_LIFO);
        issue(D1, 1'b1, 1'b0);
        drain();

        // all 0xFF, carry into bit 8
        push({4{9'h1FE}}, 1'b0, 1, CMD_FIFO);
        issue({8{8'hFF}}, 1'b0, 1'b0);
        drain();

        // back-to-back with job_valid held high
        push({9'd12, 9'd10, 9'd8, 9'd6}, 1'b0, 1, CMD_FIFO);
        push({9'd60, 9'd80, 9'd100, 9'd120}, 1'b0, 1, CMD_LIFO);
        r0 = n_res;
        issue(D1, 1'b0, 1'b1);
        issue(D2, 1'b1, 1'b0);
        chk("b2b_second_after_first_result", 64'(n_res), 64'(r0 + 1));
        drain();

        // stray output_valid during load, gapped beats, 5th beat after done
        noise = 1'b1;
        push({9'h104, 9'h103, 9'h102, 9'h101}, 1'b0, 1, CMD_FIFO);
        issue(D3, 1'b0, 1'b0);
        drain();
        noise = 1'b0;

        // busy stuck high after load
        stuck = 1'b1;
        push(36'd0, 1'b1, 0, CMD_FIFO);
        issue(D1, 1'b0, 1'b0);
        drain();
        stuck = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // reset during byte 4 of the send phase
        issue(D1, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        chk("send_byte4", 64'(datain), 64'h05);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_cmd_valid", 64'(cmd_valid), 64'd0);
        chk("midrst_job_ready", 64'(job_ready), 64'd1);
        chk("midrst_res_valid", 64'(res_valid), 64'd0);
        chk("midrst_datain", 64'(datain), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        push({9'd120, 9'd100, 9'd80, 9'd60}, 1'b0, 1, CMD_FIFO);
        issue(D2, 1'b0, 1'b0);
        drain();

        chk("cmd_valid_rule_violations", 64'(viol), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dfc_host.md
Name: dfc_host

Overview:
- Initiator-side sequencer that drives the data-fold-compute (DFC) engine's command interface on behalf of a local requester.
- Accepts one job per handshake: 8 bytes plus a read order. Issues a LOAD command, then streams the 8 bytes, then waits for the engine to go idle, then issues a FIFO or LIFO read command.
- Captures the four 9-bit results, returns them packed with a done pulse, and flags a timeout if the engine never answers.

Parameters:
- TIMEOUT, 64: max cycles from read command issue to 4th result beat before err is raised.
- GUARD, 2: cycles after the last byte during which busy is ignored, covering engine input-register latency.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- job_valid  in  1  requester offers a job.
- job_ready  out  1  host can accept a job (high only in S_IDLE).
- job_data  in  64  byte k in [8k+7:8k]; byte0 is sent first.
- job_lifo  in  1  0 = FIFO read order (cmd 2'b01), 1 = LIFO read order (cmd 2'b10).
- res_valid  out  1  one-cycle pulse; res_data/err valid.
- res_data  out  36  beat k of engine output in [9k+8:9k].
- err  out  1  with res_valid: timeout occurred; res_data holds beats received so far, zeros elsewhere.
- cmd  out  2  to engine.
- cmd_valid  out  1  to engine.
- datain  out  8  to engine.
- busy  in  1  from engine.
- dataout  in  9  from engine.
- output_valid  in  1  from engine.

Behaviour:
- Reset:
  - state S_IDLE.
  - cmd=0, cmd_valid=0, datain=0.
  - res_valid=0, res_data=0, err=0.
  - job_ready=1 the cycle after reset deasserts.
  - All counters cleared.
- Output registers: all engine-side and requester-side outputs are registered.
- Job handshake: job_valid&&job_ready latches job_data and job_lifo.
- S_IDLE → S_LOAD on accept.
- S_LOAD (1 cycle): cmd=2'b00, cmd_valid=1, datain=byte0 → S_SEND.
- S_SEND (8 cycles, byte index 0..7):
  - datain=byte[idx], cmd_valid=0.
  - The engine samples datain for 8 consecutive cycles starting the cycle after the LOAD command; no gaps are permitted.
  - After idx 7 → S_GUARD.
- S_GUARD: count GUARD cycles → S_WAIT.
- S_WAIT: when busy==0 → S_RDCMD.
- S_RDCMD (1 cycle):
  - cmd = job_lifo ? 2'b10 : 2'b01, cmd_valid=1.
  - Start the timeout counter → S_COLLECT.
- S_COLLECT:
  - Each cycle output_valid==1: store dataout into slot beat_cnt, increment beat_cnt.
  - On 4th beat → S_DONE.
  - If the timeout counter reaches TIMEOUT first → S_DONE with err=1.
  - Extra output_valid beats after the 4th are ignored.
- S_DONE (1 cycle): res_valid=1 → S_IDLE. job_ready=1 the next cycle.
- Arithmetic: no arithmetic in the host. The engine returns byte[j]+byte[j+4] (9-bit, no truncation) for j=0..3 in FIFO order; LIFO returns j=3..0. The host stores beats in arrival order, unreordered.
- cmd_valid:
  - Never asserted while busy==1, except the LOAD command in S_LOAD, which follows the engine's idle state.
  - Never asserted for more than 1 consecutive cycle.
- output_valid outside S_COLLECT: ignored.
- busy stuck high in S_WAIT: the timeout counter also runs in S_WAIT. Expiry → S_DONE with err=1, res_data=0.
- job_valid while not ready: held off; no job is lost or duplicated.
- Reset mid-job: immediate return to S_IDLE with cmd_valid=0 on the next edge. The engine is expected to be reset by the same signal.

Decomposition:
- Shared package dfc_pkg:
  - Command encodings CMD_LOAD=2'b00, CMD_FIFO=2'b01, CMD_LIFO=2'b10.
  - Constants N_BYTES=8, N_RESULTS=4, RES_W=9.
  - State enum for dfc_host.
- One sub-module is natural: dfc_host_timer, a loadable down-counter with expire flag, used in S_WAIT and S_COLLECT.
- The FSM and datapath stay in dfc_host.

Test Plan:
- Bytes 01..08, job_lifo=0, paired with a DFC engine model:
  - res_data beats = 6,8,10,12; err=0.
  - Exactly one LOAD and one FIFO cmd_valid pulse observed.
- Same bytes, job_lifo=1 → beats = 12,10,8,6; cmd=2'b10 on the read pulse.
- All bytes 0xFF, FIFO → all beats 0x1FE (carry preserved in bit 8).
- Engine model holds busy=1 forever after load, TIMEOUT=64 → res_valid with err=1 and res_data=0 within 64 cycles of entering S_WAIT.
- Back-to-back jobs with job_valid held high → second job accepted only after res_valid of the first; per-job results correct; no byte gaps in S_SEND.
- reset asserted during S_SEND byte 4 → next cycle cmd_valid=0, job_ready=1, res_valid=0; a fresh job then completes correctly.
